// File: rtl/dac_spi_capture.sv
// Capture of AD5662 24-bit write frames from the DAC pins; decodes code/power-down bits and counts frames.
// Build option: define DAC_SPI_CAPTURE_SIGNED_OUT_EN to present data_out as two's complement.
module dac_spi_capture #(
    parameter int FRAME_BITS    = 24,
    parameter int SYNC_STAGES   = 2,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     dataclk,
    input  logic                     reset,
    input  logic                     DAC_SYNC,
    input  logic                     DAC_SCLK,
    input  logic                     DAC_DIN,
    input  logic                     clear_counts,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [15:0]              data_out,
    output logic [1:0]               pd_out,
    output logic                     busy,
    output logic                     frame_error,
    output logic                     overrun,
    output logic                     overrun_sticky,
    output logic [31:0]              frame_count,
    output logic [ERR_CNT_WIDTH-1:0] error_count
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    logic sync_s, sclk_s, din_s;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sync_s = DAC_SYNC;
            assign sclk_s = DAC_SCLK;
            assign din_s  = DAC_DIN;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_pipe_reg, sclk_pipe_reg, din_pipe_reg;
            always_ff @(posedge dataclk or posedge reset) begin
                if (reset) begin
                    sync_pipe_reg <= '1;
                    sclk_pipe_reg <= '0;
                    din_pipe_reg  <= '0;
                end else begin
                    sync_pipe_reg <= SYNC_STAGES'({sync_pipe_reg, DAC_SYNC});
                    sclk_pipe_reg <= SYNC_STAGES'({sclk_pipe_reg, DAC_SCLK});
                    din_pipe_reg  <= SYNC_STAGES'({din_pipe_reg, DAC_DIN});
                end
            end
            assign sync_s = sync_pipe_reg[SYNC_STAGES-1];
            assign sclk_s = sclk_pipe_reg[SYNC_STAGES-1];
            assign din_s  = din_pipe_reg[SYNC_STAGES-1];
        end
    endgenerate

    logic sync_prev_reg, sclk_prev_reg;
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            sync_prev_reg <= 1'b1;
            sclk_prev_reg <= 1'b0;
        end else begin
            sync_prev_reg <= sync_s;
            sclk_prev_reg <= sclk_s;
        end
    end

    logic sync_fall, sync_rise, sclk_fall;
    assign sync_fall = sync_prev_reg & ~sync_s;
    assign sync_rise = ~sync_prev_reg & sync_s;
    assign sclk_fall = sclk_prev_reg & ~sclk_s;

    state_t state_reg, state_next;

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (sync_fall) state_next = ST_SHIFT;
            ST_SHIFT: if (sync_rise) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == ST_SHIFT);
    end

    // Only bits 17:0 are ever decoded; the don't-care upper bits simply fall off the top.
    logic [17:0] shift_reg, shift_next;
    logic [4:0]  bit_cnt_reg, bit_cnt_next;

    always_comb begin
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        if (sclk_fall) begin
            shift_next   = {shift_reg[16:0], din_s};
            bit_cnt_next = (bit_cnt_reg == 5'd31) ? 5'd31 : bit_cnt_reg + 5'd1;
        end
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (state_reg == ST_IDLE) begin
            if (sync_fall) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end
        end else begin
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Evaluation sees an edge that coincides with SYNC rising.
    logic frame_end, good_frame, bad_frame;
    assign frame_end  = (state_reg == ST_SHIFT) && sync_rise;
    assign good_frame = frame_end && (bit_cnt_next == 5'(FRAME_BITS));
    assign bad_frame  = frame_end && !good_frame;

    logic [15:0] code_dec;
`ifdef DAC_SPI_CAPTURE_SIGNED_OUT_EN
    assign code_dec = {~shift_next[15], shift_next[14:0]};
`else
    assign code_dec = shift_next[15:0];
`endif

    logic                     out_valid_reg, frame_error_reg, overrun_reg, overrun_sticky_reg;
    logic [15:0]              data_out_reg;
    logic [1:0]               pd_out_reg;
    logic [31:0]              frame_count_reg;
    logic [ERR_CNT_WIDTH-1:0] error_count_reg;
    logic                     overrun_event;

    assign overrun_event = good_frame && out_valid_reg && !out_ready;

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            out_valid_reg      <= 1'b0;
            data_out_reg       <= '0;
            pd_out_reg         <= '0;
            frame_error_reg    <= 1'b0;
            overrun_reg        <= 1'b0;
            overrun_sticky_reg <= 1'b0;
            frame_count_reg    <= '0;
            error_count_reg    <= '0;
        end else begin
            frame_error_reg <= bad_frame;
            overrun_reg     <= overrun_event;
            if (good_frame) begin
                data_out_reg  <= code_dec;
                pd_out_reg    <= shift_next[17:16];
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (clear_counts) begin
                frame_count_reg    <= '0;
                error_count_reg    <= '0;
                overrun_sticky_reg <= 1'b0;
            end else begin
                if (good_frame)    frame_count_reg <= frame_count_reg + 32'd1;
                if (bad_frame && (error_count_reg != '1))
                    error_count_reg <= error_count_reg + ERR_CNT_WIDTH'(1);
                if (overrun_event) overrun_sticky_reg <= 1'b1;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign data_out       = data_out_reg;
    assign pd_out         = pd_out_reg;
    assign frame_error    = frame_error_reg;
    assign overrun        = overrun_reg;
    assign overrun_sticky = overrun_sticky_reg;
    assign frame_count    = frame_count_reg;
    assign error_count    = error_count_reg;

endmodule

// File: tb/tb_dac_spi_capture.sv
// Directed bench for dac_spi_capture: default-depth instance plus a zero-stage instance for latency.
module tb_dac_spi_capture;

    logic clk = 1'b0;
    logic reset;
    logic dac_sync, dac_sclk, dac_din, clear_counts, out_ready;

    logic        out_valid, busy, frame_error, overrun, overrun_sticky;
    logic [15:0] data_out;
    logic [1:0]  pd_out;
    logic [31:0] frame_count;
    logic [15:0] error_count;

    logic        out_valid0, busy0, frame_error0, overrun0, overrun_sticky0;
    logic [15:0] data_out0;
    logic [1:0]  pd_out0;
    logic [31:0] frame_count0;
    logic [15:0] error_count0;

    always #5 clk = ~clk;

    dac_spi_capture u_dut (
        .dataclk(clk), .reset(reset), .DAC_SYNC(dac_sync), .DAC_SCLK(dac_sclk), .DAC_DIN(dac_din),
        .clear_counts(clear_counts), .out_ready(out_ready), .out_valid(out_valid),
        .data_out(data_out), .pd_out(pd_out), .busy(busy), .frame_error(frame_error),
        .overrun(overrun), .overrun_sticky(overrun_sticky), .frame_count(frame_count),
        .error_count(error_count)
    );

    dac_spi_capture #(.SYNC_STAGES(0)) u_dut0 (
        .dataclk(clk), .reset(reset), .DAC_SYNC(dac_sync), .DAC_SCLK(dac_sclk), .DAC_DIN(dac_din),
        .clear_counts(clear_counts), .out_ready(out_ready), .out_valid(out_valid0),
        .data_out(data_out0), .pd_out(pd_out0), .busy(busy0), .frame_error(frame_error0),
        .overrun(overrun0), .overrun_sticky(overrun_sticky0), .frame_count(frame_count0),
        .error_count(error_count0)
    );

    int cyc = 0;
    int valid_cycles = 0, err_pulses = 0, ovr_pulses = 0;
    int rise_cyc2 = 0, rise_cyc0 = 0, rise_set_cyc = 0;
    logic valid_d = 1'b0, valid0_d = 1'b0;
    int checks = 0, passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid)   valid_cycles <= valid_cycles + 1;
        if (frame_error) err_pulses   <= err_pulses + 1;
        if (overrun)     ovr_pulses   <= ovr_pulses + 1;
        if (out_valid && !valid_d)   rise_cyc2 <= cyc;
        if (out_valid0 && !valid0_d) rise_cyc0 <= cyc;
        valid_d  <= out_valid;
        valid0_d <= out_valid0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        $display("check %-16s observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_frame(input logic [23:0] word, input int nbits, input bit merge);
        dac_sync = 1'b0;
        tick(3);
        for (int i = 0; i < nbits; i++) begin
            dac_din  = (i < 24) ? word[23 - i] : 1'b0;
            dac_sclk = 1'b1;
            tick(2);
            dac_sclk = 1'b0;
            if (merge && (i == nbits - 1)) begin
                dac_sync     = 1'b1;
                rise_set_cyc = cyc;
            end
            tick(2);
        end
        if (!merge) begin
            dac_sync     = 1'b1;
            rise_set_cyc = cyc;
        end
        tick(8);
        $display("frame 0x%06h bits=%0d merge=%0d -> data_out=0x%04h pd=%0d fc=%0d ec=%0d",
                 word, nbits, merge, data_out, pd_out, frame_count, error_count);
    endtask

    initial begin
        reset = 1'b1; dac_sync = 1'b1; dac_sclk = 1'b0; dac_din = 1'b0;
        clear_counts = 1'b0; out_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_fc", frame_count, 32'd0);
        check("rst_ec", 32'(error_count), 32'd0);
        check("rst_sticky", 32'(overrun_sticky), 32'd0);

        // SCLK activity while SYNC is high must be ignored
        repeat (3) begin
            dac_sclk = 1'b1; tick(2); dac_sclk = 1'b0; tick(2);
        end
        tick(4);
        check("idle_sclk_err", 32'(err_pulses), 32'd0);

        send_frame(24'h00A5C3, 24, 1'b0);
        check("t1_valid_cyc", 32'(valid_cycles), 32'd1);
        check("t1_data", 32'(data_out), 32'hA5C3);
        check("t1_pd", 32'(pd_out), 32'd0);
        check("t1_fc", frame_count, 32'd1);
        check("t1_ec", 32'(error_count), 32'd0);

        send_frame(24'hFFFFFF, 20, 1'b0);
        check("short_pulse", 32'(err_pulses), 32'd1);
        check("short_ec", 32'(error_count), 32'd1);
        check("short_valid", 32'(valid_cycles), 32'd1);
        check("short_data", 32'(data_out), 32'hA5C3);
        send_frame(24'h123456, 25, 1'b0);
        check("long_ec", 32'(error_count), 32'd2);
        send_frame(24'h000000, 0, 1'b0);
        check("zero_ec", 32'(error_count), 32'd3);
        check("zero_fc", frame_count, 32'd1);

        out_ready = 1'b0;
        send_frame(24'h021234, 24, 1'b0);
        check("ov1_pulses", 32'(ovr_pulses), 32'd0);
        check("ov1_data", 32'(data_out), 32'h1234);
        check("ov1_pd", 32'(pd_out), 32'd2);
        send_frame(24'hFDBEEF, 24, 1'b0);
        check("ov2_pulses", 32'(ovr_pulses), 32'd1);
        check("ov2_sticky", 32'(overrun_sticky), 32'd1);
        check("ov2_data", 32'(data_out), 32'hBEEF);
        check("ov2_pd", 32'(pd_out), 32'd1);
        check("ov2_fc", frame_count, 32'd3);
        check("ov2_valid", 32'(out_valid), 32'd1);
        clear_counts = 1'b1; tick(1); clear_counts = 1'b0; tick(1);
        check("clr_fc", frame_count, 32'd0);
        check("clr_ec", 32'(error_count), 32'd0);
        check("clr_sticky", 32'(overrun_sticky), 32'd0);
        check("clr_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; tick(2);
        check("ready_drain", 32'(out_valid), 32'd0);

        // Abort a frame with reset after 10 edges
        dac_sync = 1'b0; tick(3);
        for (int i = 0; i < 10; i++) begin
            dac_din = 1'b1; dac_sclk = 1'b1; tick(2); dac_sclk = 1'b0; tick(2);
        end
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1; tick(2);
        dac_sync = 1'b1; tick(2);
        reset = 1'b0; tick(4);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_fc", frame_count, 32'd0);
        check("rst2_data", 32'(data_out), 32'd0);
        send_frame(24'h007FFF, 24, 1'b0);
        check("rst2_new_data", 32'(data_out), 32'h7FFF);
        check("rst2_new_fc", frame_count, 32'd1);
        check("rst2_new_ec", 32'(error_count), 32'd0);
        check("rst2_err_pulse", 32'(err_pulses), 32'd3);

        send_frame(24'h000001, 24, 1'b1);
        check("merge_data", 32'(data_out), 32'h0001);
        check("merge_fc", frame_count, 32'd2);
        check("lat_stages2", 32'(rise_cyc2 - rise_set_cyc), 32'd3);
        check("lat_stages0", 32'(rise_cyc0 - rise_set_cyc), 32'd1);
        check("merge_data0", 32'(data_out0), 32'h0001);

        send_frame(24'h008000, 24, 1'b0);
`ifdef DAC_SPI_CAPTURE_SIGNED_OUT_EN
        check("code_8000", 32'(data_out), 32'h0000);
`else
        check("code_8000", 32'(data_out), 32'h8000);
`endif
        send_frame(24'h000000, 24, 1'b0);
`ifdef DAC_SPI_CAPTURE_SIGNED_OUT_EN
        check("code_0000", 32'(data_out), 32'h8000);
`else
        check("code_0000", 32'(data_out), 32'h0000);
`endif
        check("final_fc", frame_count, 32'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
